// File: rtl/cargador_trabajo_pkg.sv
// Shared definitions for the work loader: state encoding, default byte
// width and frame sizing.
package cargador_trabajo_pkg;

  localparam int BYTE_DEF    = 8;
  localparam int N_DATOS_DEF = 12;
  localparam int LONG_TRAMA  = N_DATOS_DEF + 1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ARM    = 2'd1,
    RUN    = 2'd2,
    RESULT = 2'd3
  } estado_t;

  // Header bytes plus the trailing target byte.
  function automatic int long_trama(input int n_datos);
    return n_datos + 1;
  endfunction

endpackage

// File: rtl/contador_ciclos.sv
// Run-time cycle counter with synchronous clear, enable and a terminal
// count flag raised while the count equals MAX_CICLOS-1.
module contador_ciclos #(
  parameter int MAX_CICLOS = 65536,
  parameter int CNT_W      = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(MAX_CICLOS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TERMINAL);

endmodule

// File: rtl/cargador_trabajo.sv
// Work loader: assembles a byte-serial header+target frame, sequences the
// mining system's reset around the job and holds the captured nonce.
module cargador_trabajo
  import cargador_trabajo_pkg::*;
#(
  parameter int BYTE       = BYTE_DEF,
  parameter int N_DATOS    = N_DATOS_DEF,
  parameter int MAX_CICLOS = 65536,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BYTE-1:0]         byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic [N_DATOS*BYTE-1:0] data_out,
  output logic [BYTE-1:0]         target_out,
  output logic                    sistema_reset,
  input  logic                    finished,
  input  logic [31:0]             nonce_in,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [31:0]             result_nonce,
  output logic                    result_timeout,
  output logic                    busy
);

  localparam int DATA_W = N_DATOS * BYTE;
  localparam int TRAMA  = long_trama(N_DATOS);
  localparam int IDX_W  = $clog2(TRAMA + 1);
  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(N_DATOS);

  estado_t           state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BYTE-1:0]   target_q, target_d;
  logic [31:0]       nonce_q, nonce_d;
  logic              sres_q, sres_d;
  logic              rvalid_q, rvalid_d;
  logic              rto_q, rto_d;
  logic              tc;

  contador_ciclos #(
    .MAX_CICLOS(MAX_CICLOS),
    .CNT_W     (CNT_W)
  ) u_contador (
    .clk  (clk),
    .rst  (reset),
    .clr_i(state_q == ARM),
    .en_i (state_q == RUN),
    .tc_o (tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    target_d = target_q;
    nonce_d  = nonce_q;
    rvalid_d = rvalid_q;
    rto_d    = rto_q;
    case (state_q)
      LOAD: begin
        if (byte_valid) begin
          if (idx_q == ULTIMO) begin
            target_d = byte_in;
            state_d  = ARM;
          end else begin
            // Byte 0 lands in the most significant slot of the header.
            data_d[DATA_W-1-BYTE*int'(idx_q) -: BYTE] = byte_in;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ARM: state_d = RUN;
      RUN: begin
        if (finished) begin
          nonce_d  = nonce_in;
          rto_d    = 1'b0;
          rvalid_d = 1'b1;
          state_d  = RESULT;
        end else if (tc) begin
          nonce_d  = nonce_in;
          rto_d    = 1'b1;
          rvalid_d = 1'b1;
          state_d  = RESULT;
        end
      end
      RESULT: begin
        if (result_ready) begin
          rvalid_d = 1'b0;
          idx_d    = '0;
          state_d  = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
    // The system leaves reset only from the second RUN cycle on, and is
    // frozen again on the same edge that captures the result.
    sres_d = !((state_q == RUN) && (state_d == RUN));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      data_q   <= '0;
      target_q <= '0;
      nonce_q  <= '0;
      sres_q   <= 1'b1;
      rvalid_q <= 1'b0;
      rto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      target_q <= target_d;
      nonce_q  <= nonce_d;
      sres_q   <= sres_d;
      rvalid_q <= rvalid_d;
      rto_q    <= rto_d;
    end
  end

  assign byte_ready     = (state_q == LOAD);
  assign busy           = (state_q != LOAD);
  assign data_out       = data_q;
  assign target_out     = target_q;
  assign sistema_reset  = sres_q;
  assign result_valid   = rvalid_q;
  assign result_nonce   = nonce_q;
  assign result_timeout = rto_q;

endmodule

// File: tb/tb_cargador_trabajo.sv
// Self-checking bench for cargador_trabajo with a small job-level model.
module tb_cargador_trabajo;

  localparam int MAXC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [95:0] data_out;
  logic [7:0]  target_out;
  logic        sistema_reset;
  logic        finished = 1'b0;
  logic [31:0] nonce_in = '0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] result_nonce;
  logic        result_timeout;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [95:0] exp_data_m = '0;
  logic [7:0]  exp_tgt_m  = '0;
  logic [31:0] exp_nonce_m = '0;
  bit          exp_to_m = 1'b0;

  cargador_trabajo #(
    .BYTE(8), .N_DATOS(12), .MAX_CICLOS(MAXC), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .data_out(data_out), .target_out(target_out),
    .sistema_reset(sistema_reset), .finished(finished), .nonce_in(nonce_in),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_nonce(result_nonce), .result_timeout(result_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Sends a 13-byte frame with optional idle gaps, then checks the ARM state.
  task automatic send_frame(input logic [7:0] fr [13], input int max_gap);
    logic [95:0] exp_d;
    int g;
    for (int i = 0; i < 13; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        byte_valid = 1'b0;
        byte_in = 8'($urandom);
        @(posedge clk); #1;
      end
      byte_in = fr[i];
      byte_valid = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    exp_d = '0;
    for (int i = 0; i < 12; i++) exp_d = {exp_d[87:0], fr[i]};
    exp_data_m = exp_d;
    exp_tgt_m = fr[12];
    checks++;
    if (data_out !== exp_d) begin
      errors++; $display("FAIL data_out got %h want %h", data_out, exp_d);
    end
    checks++;
    if (target_out !== fr[12]) begin
      errors++; $display("FAIL target_out got %h want %h", target_out, fr[12]);
    end
    checks++;
    if ({byte_ready, sistema_reset, busy} !== 3'b011) begin
      errors++; $display("FAIL arm_flags got rdy/sres/busy=%b want 011", {byte_ready, sistema_reset, busy});
    end
  endtask

  // Drives one RUN phase; finished is raised on RUN cycle k (0 = never).
  task automatic run_job(input int k, input logic [31:0] fixed_nonce, input bit rnd_nonce, input bit junk);
    int fin;
    @(posedge clk); #1;
    checks++;
    if ({sistema_reset, result_valid} !== 2'b10) begin
      errors++; $display("FAIL run1_flags got sres/rv=%b want 10", {sistema_reset, result_valid});
    end
    fin = (k >= 1 && k <= MAXC) ? k : MAXC;
    exp_to_m = !(k >= 1 && k <= MAXC);
    for (int c = 1; c <= fin; c++) begin
      finished = (c == k);
      nonce_in = rnd_nonce ? $urandom : fixed_nonce;
      if (c == fin) exp_nonce_m = nonce_in;
      byte_valid = junk ? 1'($urandom_range(1, 0)) : 1'b0;
      byte_in = 8'($urandom);
      @(posedge clk); #1;
      if (c < fin) begin
        checks++;
        if ({sistema_reset, result_valid} !== 2'b00) begin
          errors++; $display("FAIL running cycle %0d got sres/rv=%b want 00", c, {sistema_reset, result_valid});
        end
      end
    end
    finished = 1'b0;
    byte_valid = 1'b0;
    checks++;
    if ({result_valid, sistema_reset, busy, byte_ready} !== 4'b1110) begin
      errors++; $display("FAIL result_flags got rv/sres/busy/rdy=%b want 1110", {result_valid, sistema_reset, busy, byte_ready});
    end
    checks++;
    if (result_nonce !== exp_nonce_m) begin
      errors++; $display("FAIL result_nonce got %h want %h", result_nonce, exp_nonce_m);
    end
    checks++;
    if (result_timeout !== exp_to_m) begin
      errors++; $display("FAIL result_timeout got %b want %b", result_timeout, exp_to_m);
    end
  endtask

  // Holds the result for 'hold' cycles, then completes the handshake.
  task automatic take_result(input int hold);
    result_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      finished = 1'($urandom_range(1, 0));
      nonce_in = $urandom;
      @(posedge clk); #1;
      checks++;
      if ({result_valid, result_timeout, result_nonce} !== {1'b1, exp_to_m, exp_nonce_m}) begin
        errors++; $display("FAIL hold cycle %0d got v/to/n=%b/%b/%h want 1/%b/%h", h, result_valid, result_timeout, result_nonce, exp_to_m, exp_nonce_m);
      end
    end
    finished = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    checks++;
    if ({result_valid, byte_ready, busy, sistema_reset} !== 4'b0101) begin
      errors++; $display("FAIL handshake got rv/rdy/busy/sres=%b want 0101", {result_valid, byte_ready, busy, sistema_reset});
    end
    checks++;
    if ({data_out, target_out} !== {exp_data_m, exp_tgt_m}) begin
      errors++; $display("FAIL retained got %h/%h want %h/%h", data_out, target_out, exp_data_m, exp_tgt_m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({byte_ready, sistema_reset, result_valid, result_timeout, busy} !== 5'b11000) begin
      errors++; $display("FAIL reset_flags got %b want 11000", {byte_ready, sistema_reset, result_valid, result_timeout, busy});
    end
    checks++;
    if ({data_out, target_out, result_nonce} !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h want zero", data_out, target_out, result_nonce);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_frame();
    logic [7:0] fr [13];
    for (int i = 0; i < 12; i++) fr[i] = 8'(i + 1);
    fr[12] = 8'h10;
    send_frame(fr, 0);
    checks++;
    if (data_out !== 96'h0102030405060708090A0B0C) begin
      errors++; $display("FAIL load_const got %h want 0102030405060708090a0b0c", data_out);
    end
  endtask

  task automatic test_normal_result();
    run_job(3, 32'h000000A5, 1'b0, 1'b0);
    checks++;
    if ({result_nonce, result_timeout} !== {32'h000000A5, 1'b0}) begin
      errors++; $display("FAIL normal got %h/%b want 000000a5/0", result_nonce, result_timeout);
    end
  endtask

  task automatic test_backpressure();
    take_result(5);
  endtask

  task automatic test_timeout();
    logic [7:0] fr [13];
    for (int i = 0; i < 13; i++) fr[i] = 8'($urandom);
    send_frame(fr, 1);
    run_job(0, 32'h00001234, 1'b0, 1'b0);
    checks++;
    if ({result_nonce, result_timeout} !== {32'h00001234, 1'b1}) begin
      errors++; $display("FAIL timeout got %h/%b want 00001234/1", result_nonce, result_timeout);
    end
    take_result(0);
  endtask

  task automatic test_collision();
    logic [7:0] fr [13];
    for (int i = 0; i < 13; i++) fr[i] = 8'($urandom);
    send_frame(fr, 0);
    run_job(MAXC, 32'h0, 1'b1, 1'b0);
    take_result(1);
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] fr [13];
    for (int i = 0; i < 5; i++) begin
      byte_in = 8'hA0 + 8'(i);
      byte_valid = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    reset = 1'b1;
    #2;
    checks++;
    if ({byte_ready, busy, sistema_reset, data_out, target_out} !== {3'b101, 104'h0}) begin
      errors++; $display("FAIL midload_reset got rdy/busy/sres=%b data=%h", {byte_ready, busy, sistema_reset}, data_out);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) fr[i] = 8'hF0 + 8'(i);
    fr[12] = 8'h20;
    send_frame(fr, 0);
    checks++;
    if ({data_out, target_out} !== {96'hF0F1F2F3F4F5F6F7F8F9FAFB, 8'h20}) begin
      errors++; $display("FAIL midload_frame got %h/%h want f0f1f2f3f4f5f6f7f8f9fafb/20", data_out, target_out);
    end
    run_job(2, 32'h0, 1'b1, 1'b0);
    take_result(0);
  endtask

  task automatic test_random_jobs();
    logic [7:0] fr [13];
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 13; i++) fr[i] = 8'($urandom);
      send_frame(fr, 2);
      run_job(int'($urandom_range(MAXC + 4, 1)), 32'h0, 1'b1, 1'b1);
      take_result(int'($urandom_range(3, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_load_frame();
    test_normal_result();
    test_backpressure();
    test_timeout();
    test_collision();
    test_reset_mid_load();
    test_random_jobs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cargador_trabajo.md
Name: cargador_trabajo

Overview:
Upstream feeder for the mining system. It receives a byte-serial work frame of 12 header bytes plus 1 target byte over a valid/ready handshake and assembles the 96-bit data_in and 8-bit target buses. It sequences the system's reset around each job and captures nonce_out when finished rises, or when a cycle budget expires. It then holds the result until a consumer takes it.

Parameters:
BYTE, 8, width of one frame byte.
N_DATOS, 12, header bytes per frame (data_out width = N_DATOS*BYTE).
MAX_CICLOS, 65536, RUN-state cycle budget before timeout (>=2).
CNT_W, 32, width of the run cycle counter (must hold MAX_CICLOS-1).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; returns block to reset values.
byte_in  in  BYTE  frame byte.
byte_valid  in  1  byte_in valid.
byte_ready  out  1  block accepts a byte this cycle.
data_out  out  N_DATOS*BYTE  assembled header; drives the system's data_in.
target_out  out  8  assembled target; drives the system's target.
sistema_reset  out  1  active-high reset to the mining system.
finished  in  1  from system: valid nonce found.
nonce_in  in  32  from system: nonce_out.
result_valid  out  1  captured result available.
result_ready  in  1  consumer accepts result.
result_nonce  out  32  captured nonce.
result_timeout  out  1  result produced by budget expiry, not finished.
busy  out  1  high in ARM, RUN and RESULT.

Behaviour:
- Reset values: byte_ready=1, data_out=0, target_out=0, sistema_reset=1, result_valid=0, result_nonce=0, result_timeout=0, busy=0, state=LOAD, byte count=0, run counter=0.
- States: LOAD, ARM, RUN, RESULT. All outputs are registered, except that byte_ready and busy are decoded from the state.
- LOAD:
  - byte_ready=1, sistema_reset=1.
  - A byte is accepted on a clk edge with byte_valid&&byte_ready.
  - Bytes 0..N_DATOS-1 fill data_out MSB-first: byte 0 goes to [95:88], byte 11 to [7:0].
  - Byte N_DATOS goes to target_out.
  - Acceptance of the last byte moves the block to ARM.
- ARM: exactly 1 cycle. byte_ready=0, sistema_reset stays 1 with data and target stable. Next state is RUN, with the run counter cleared.
- RUN:
  - sistema_reset=0; the counter increments each cycle.
  - finished=1 sampled: capture nonce_in into result_nonce, result_timeout=0, go to RESULT.
  - Otherwise, counter==MAX_CICLOS-1: capture nonce_in, result_timeout=1, go to RESULT.
  - finished and the budget expiring in the same cycle: finished wins, timeout=0.
- RESULT:
  - result_valid=1 and sistema_reset=1 (system frozen).
  - Result fields are held stable while result_valid && !result_ready.
  - On result_valid&&result_ready: result_valid=0, byte count=0, go to LOAD. data_out and target_out are retained until overwritten.
- Bytes presented while byte_ready=0 are ignored and not queued.
- finished is ignored outside RUN.
- Latency:
  - Last byte accepted at edge N; sistema_reset falls at edge N+2.
  - finished sampled at edge M; result_valid=1 after edge M.
- Reset mid-operation (any state): partial frame discarded, reset values restored immediately (asynchronous).

Decomposition:
- Shared package/include: state encodings (LOAD=2'd0, ARM=2'd1, RUN=2'd2, RESULT=2'd3), frame length constant N_DATOS+1, and the BYTE default.
- One natural sub-module: contador_ciclos, the run counter with clear, enable and terminal-count flag at MAX_CICLOS-1.
- Byte assembly and the FSM stay in cargador_trabajo.

Test Plan:
1. Load frame: send bytes 0x01..0x0C then 0x10 back-to-back. Required: data_out=0x0102030405060708090A0B0C, target_out=0x10, byte_ready=0 after the 13th byte, sistema_reset falls 2 edges later.
2. Normal result: in RUN, assert finished with nonce_in=0x000000A5. Required: result_valid=1 next cycle, result_nonce=0x000000A5, result_timeout=0, sistema_reset=1.
3. Backpressure: hold result_ready=0 for 5 cycles, then pulse it 1 cycle. Required: result fields stable for the 5 cycles; LOAD with byte_ready=1 after the handshake.
4. Timeout: MAX_CICLOS=16, finished held 0, nonce_in=0x00001234. Required: result_valid after the 16th RUN cycle, result_timeout=1, result_nonce=0x00001234.
5. Collision: MAX_CICLOS=16, finished=1 on RUN cycle 16. Required: result_timeout=0.
6. Reset mid-load: assert reset after 5 bytes, release, send a full frame 0xF0..0xFB, 0x20. Required: data_out=0xF0F1F2F3F4F5F6F7F8F9FAFB, target_out=0x20, with no residue from the earlier bytes.
